victim_fifo_buffer: RTL and testbench

Multi-entry, parametrised write-back eviction buffer between the L1 data cache and the memory arbiter. It absorbs up to DEPTH dirty victim lines with single-cycle acknowledge and coalesces repeat evictions of the same line. It serves cache read misses either directly from buffered victims or by forwarding them to the arbiter. Buffered lines drain to memory in FIFO order whenever the cache side is quiet.

---
 rtl/victim_fifo_buffer.sv | 155 +++++++++++++++
 tb/tb_victim_fifo_buffer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/victim_fifo_buffer.sv
// Write-back victim buffer between the L1 dcache and the memory arbiter.
// Coalesces repeat evictions, serves read hits from buffered victims, drains FIFO-order when idle.
module victim_fifo_buffer #(
  parameter int CACHELINE_SIZE = 256,
  parameter int DEPTH          = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               from_dcache_address,
  input  logic                      from_dcache_write,
  input  logic                      from_dcache_read,
  input  logic [CACHELINE_SIZE-1:0] from_dcache_wdata,
  output logic [CACHELINE_SIZE-1:0] to_dcache_rdata,
  output logic                      to_dcache_resp,
  input  logic [CACHELINE_SIZE-1:0] from_arbiter_rdata,
  input  logic                      from_arbiter_resp,
  output logic                      to_arbiter_read,
  output logic                      to_arbiter_write,
  output logic [31:0]               to_arbiter_address,
  output logic [CACHELINE_SIZE-1:0] to_arbiter_wdata,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full
);
  localparam int OFFSET = $clog2(CACHELINE_SIZE/8);
  localparam int TAG_W  = 32 - OFFSET;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, READ, WB} state_e;

  state_e                                 state_q, state_d;
  logic [DEPTH-1:0]                       valid_q, valid_d;
  logic [DEPTH-1:0][TAG_W-1:0]            tag_q;
  logic [DEPTH-1:0][CACHELINE_SIZE-1:0]   data_q;
  logic [PTR_W-1:0]                       head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                       count_q, count_d;

  logic [TAG_W-1:0] req_tag;
  logic             hit;
  logic [PTR_W-1:0] hit_idx;
  logic             push, upd, pop;
  logic             unused_addr_bits;

  assign req_tag          = from_dcache_address[31:OFFSET];
  assign unused_addr_bits = ^from_dcache_address[OFFSET-1:0];
  assign full             = (count_q == CNT_W'(DEPTH));
  assign count            = count_q;

  // At most one valid entry can carry a given tag, so a priority scan is a plain select.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && tag_q[i] == req_tag) begin
        hit     = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign push = (state_q == IDLE) && from_dcache_write && !hit && !full;
  assign upd  = (state_q == IDLE) && from_dcache_write && hit;
  assign pop  = (state_q == WB) && from_arbiter_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[tail_q]  <= req_tag;
      data_q[tail_q] <= from_dcache_wdata;
    end else if (upd) begin
      data_q[hit_idx] <= from_dcache_wdata;
    end
  end

  always_comb begin
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
      count_d         = count_q + 1'b1;
    end else if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
      count_d         = count_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (from_dcache_write) begin
          if (!hit && full) state_d = WB;
        end else if (from_dcache_read) begin
          if (!hit) state_d = READ;
        end else if (count_q != '0) begin
          state_d = WB;
        end
      end
      READ:    if (from_arbiter_resp) state_d = IDLE;
      WB:      if (from_arbiter_resp) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    to_dcache_rdata    = '0;
    to_dcache_resp     = 1'b0;
    to_arbiter_read    = 1'b0;
    to_arbiter_write   = 1'b0;
    to_arbiter_address = '0;
    to_arbiter_wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (from_dcache_write) begin
          to_dcache_resp = hit || !full;
        end else if (from_dcache_read && hit) begin
          to_dcache_resp  = 1'b1;
          to_dcache_rdata = data_q[hit_idx];
        end
      end
      READ: begin
        to_arbiter_read    = 1'b1;
        to_arbiter_address = {req_tag, {OFFSET{1'b0}}};
        to_dcache_rdata    = from_arbiter_rdata;
        to_dcache_resp     = from_arbiter_resp;
      end
      WB: begin
        to_arbiter_write   = 1'b1;
        to_arbiter_address = {tag_q[head_q], {OFFSET{1'b0}}};
        to_arbiter_wdata   = data_q[head_q];
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_victim_fifo_buffer.sv
// Directed bench for victim_fifo_buffer (CACHELINE_SIZE=256, DEPTH=4).
module tb_victim_fifo_buffer;
  localparam int CL = 256;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   from_dcache_address;
  logic          from_dcache_write, from_dcache_read;
  logic [CL-1:0] from_dcache_wdata, to_dcache_rdata;
  logic          to_dcache_resp;
  logic [CL-1:0] from_arbiter_rdata;
  logic          from_arbiter_resp;
  logic          to_arbiter_read, to_arbiter_write;
  logic [31:0]   to_arbiter_address;
  logic [CL-1:0] to_arbiter_wdata;
  logic [2:0]    count;
  logic          full;

  int checks = 0;
  int errors = 0;

  logic [CL-1:0] D1, D2, D3, D4, D5;
  logic [CL-1:0] E [5];

  victim_fifo_buffer #(.CACHELINE_SIZE(CL), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .from_dcache_address(from_dcache_address), .from_dcache_write(from_dcache_write),
    .from_dcache_read(from_dcache_read), .from_dcache_wdata(from_dcache_wdata),
    .to_dcache_rdata(to_dcache_rdata), .to_dcache_resp(to_dcache_resp),
    .from_arbiter_rdata(from_arbiter_rdata), .from_arbiter_resp(from_arbiter_resp),
    .to_arbiter_read(to_arbiter_read), .to_arbiter_write(to_arbiter_write),
    .to_arbiter_address(to_arbiter_address), .to_arbiter_wdata(to_arbiter_wdata),
    .count(count), .full(full)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; from_dcache_address = '0; from_dcache_write = 0; from_dcache_read = 0;
    from_dcache_wdata = '0; from_arbiter_rdata = '0; from_arbiter_resp = 0;
    cyc(); cyc(); #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++;
    if ({to_dcache_resp, to_arbiter_read, to_arbiter_write} !== 3'b000 || to_arbiter_address !== 32'h0 ||
        to_dcache_rdata !== '0 || to_arbiter_wdata !== '0) begin
      errors++; $display("FAIL reset_outputs got resp=%b rd=%b wr=%b addr=%h exp all 0",
                         to_dcache_resp, to_arbiter_read, to_arbiter_write, to_arbiter_address);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    cyc(); from_dcache_write = 1; from_dcache_address = 32'h100; from_dcache_wdata = D1; #1;
    checks++; if (to_dcache_resp !== 1'b1) begin errors++; $display("FAIL sw_resp got %b exp 1", to_dcache_resp); end
    cyc(); from_dcache_write = 0; #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL sw_count got %0d exp 1", count); end
    checks++; if (to_arbiter_write !== 1'b0) begin errors++; $display("FAIL sw_idle_gap got %b exp 0", to_arbiter_write); end
    cyc(); #1;
    checks++; if (to_arbiter_write !== 1'b1) begin errors++; $display("FAIL sw_wb_start got %b exp 1", to_arbiter_write); end
    checks++; if (to_arbiter_address !== 32'h100) begin errors++; $display("FAIL sw_wb_addr got %h exp 100", to_arbiter_address); end
    checks++; if (to_arbiter_wdata !== D1) begin errors++; $display("FAIL sw_wb_data got %h exp %h", to_arbiter_wdata, D1); end
    cyc(); cyc(); from_arbiter_resp = 1; #1;
    checks++; if (to_arbiter_address !== 32'h100) begin errors++; $display("FAIL sw_wb_hold got %h exp 100", to_arbiter_address); end
    cyc(); from_arbiter_resp = 0; #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL sw_pop_count got %0d exp 0", count); end
    checks++; if (to_arbiter_write !== 1'b0) begin errors++; $display("FAIL sw_back_idle got %b exp 0", to_arbiter_write); end
  endtask

  task automatic test_coalesce();
    cyc(); from_dcache_write = 1; from_dcache_address = 32'h100; from_dcache_wdata = D1; #1;
    checks++; if (to_dcache_resp !== 1'b1) begin errors++; $display("FAIL co_resp1 got %b exp 1", to_dcache_resp); end
    cyc(); from_dcache_address = 32'h104; from_dcache_wdata = D2; #1;
    checks++; if (to_dcache_resp !== 1'b1) begin errors++; $display("FAIL co_resp2 got %b exp 1", to_dcache_resp); end
    cyc(); from_dcache_write = 0; #1;
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL co_count got %0d exp 1", count); end
    cyc(); #1;
    checks++; if (to_arbiter_write !== 1'b1 || to_arbiter_wdata !== D2 || to_arbiter_address !== 32'h100) begin
      errors++; $display("FAIL co_wb got wr=%b addr=%h data=%h exp 1/100/%h", to_arbiter_write, to_arbiter_address, to_arbiter_wdata, D2);
    end
    from_arbiter_resp = 1;
    cyc(); from_arbiter_resp = 0; #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL co_drained got %0d exp 0", count); end
  endtask

  task automatic test_full_wrap();
    logic [31:0] exp_addr;
    for (int i = 0; i < 4; i++) begin
      cyc(); from_dcache_write = 1; from_dcache_address = 32'(i * 32'h20); from_dcache_wdata = E[i]; #1;
      checks++; if (to_dcache_resp !== 1'b1) begin errors++; $display("FAIL fw_fill_resp%0d got %b exp 1", i, to_dcache_resp); end
    end
    cyc(); from_dcache_address = 32'h080; from_dcache_wdata = E[4]; #1;
    checks++; if (full !== 1'b1 || count !== 3'd4) begin errors++; $display("FAIL fw_full got full=%b count=%0d exp 1/4", full, count); end
    checks++; if (to_dcache_resp !== 1'b0) begin errors++; $display("FAIL fw_full_stall got %b exp 0", to_dcache_resp); end
    cyc(); #1;
    checks++; if (to_arbiter_write !== 1'b1 || to_arbiter_address !== 32'h000 || to_dcache_resp !== 1'b0) begin
      errors++; $display("FAIL fw_evict_head got wr=%b addr=%h resp=%b exp 1/0/0", to_arbiter_write, to_arbiter_address, to_dcache_resp);
    end
    from_arbiter_resp = 1;
    cyc(); from_arbiter_resp = 0; #1;
    for (int k = 0; k < 6 && !to_dcache_resp; k++) begin cyc(); #1; end
    checks++; if (to_dcache_resp !== 1'b1) begin errors++; $display("FAIL fw_accept_after_pop got %b exp 1", to_dcache_resp); end
    cyc(); from_dcache_write = 0; #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fw_refull got %0d exp 4", count); end
    for (int i = 1; i < 5; i++) begin
      exp_addr = 32'(i * 32'h20);
      for (int k = 0; k < 6 && !to_arbiter_write; k++) begin cyc(); #1; end
      checks++;
      if (to_arbiter_write !== 1'b1 || to_arbiter_address !== exp_addr || to_arbiter_wdata !== E[i]) begin
        errors++; $display("FAIL fw_drain%0d got wr=%b addr=%h exp 1/%h", i, to_arbiter_write, to_arbiter_address, exp_addr);
      end
      from_arbiter_resp = 1;
      cyc(); from_arbiter_resp = 0; #1;
    end
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL fw_empty got %0d exp 0", count); end
  endtask

  task automatic test_read_hit_and_miss();
    cyc(); from_dcache_write = 1; from_dcache_address = 32'h200; from_dcache_wdata = D3; #1;
    cyc(); from_dcache_write = 0; from_dcache_read = 1; from_dcache_address = 32'h210; #1;
    checks++; if (to_dcache_resp !== 1'b1 || to_dcache_rdata !== D3) begin
      errors++; $display("FAIL rh_hit got resp=%b data=%h exp 1/%h", to_dcache_resp, to_dcache_rdata, D3);
    end
    cyc(); from_dcache_read = 0; #1;
    checks++; if (to_arbiter_read !== 1'b0 || count !== 3'd1) begin
      errors++; $display("FAIL rh_no_fetch got rd=%b count=%0d exp 0/1", to_arbiter_read, count);
    end
    cyc(); #1;
    checks++; if (to_arbiter_write !== 1'b1 || to_arbiter_address !== 32'h200) begin
      errors++; $display("FAIL rm_wb got wr=%b addr=%h exp 1/200", to_arbiter_write, to_arbiter_address);
    end
    from_dcache_read = 1; from_dcache_address = 32'h400; #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (to_dcache_resp !== 1'b0 || to_arbiter_read !== 1'b0) begin
        errors++; $display("FAIL rm_blocked%0d got resp=%b rd=%b exp 0/0", k, to_dcache_resp, to_arbiter_read);
      end
      if (k < 2) begin cyc(); #1; end
    end
    from_arbiter_resp = 1;
    cyc(); from_arbiter_resp = 0; #1;
    checks++; if (to_dcache_resp !== 1'b0 || count !== 3'd0) begin
      errors++; $display("FAIL rm_idle_miss got resp=%b count=%0d exp 0/0", to_dcache_resp, count);
    end
    cyc(); from_arbiter_rdata = D4; #1;
    checks++; if (to_arbiter_read !== 1'b1 || to_arbiter_address !== 32'h400 || to_arbiter_write !== 1'b0) begin
      errors++; $display("FAIL rm_fetch got rd=%b addr=%h wr=%b exp 1/400/0", to_arbiter_read, to_arbiter_address, to_arbiter_write);
    end
    checks++; if (to_dcache_resp !== 1'b0 || to_dcache_rdata !== D4) begin
      errors++; $display("FAIL rm_pass_wait got resp=%b data=%h exp 0/%h", to_dcache_resp, to_dcache_rdata, D4);
    end
    from_arbiter_resp = 1; #1;
    checks++; if (to_dcache_resp !== 1'b1) begin errors++; $display("FAIL rm_pass_resp got %b exp 1", to_dcache_resp); end
    cyc(); from_arbiter_resp = 0; from_dcache_read = 0; from_arbiter_rdata = '0; #1;
    checks++; if (to_arbiter_read !== 1'b0) begin errors++; $display("FAIL rm_done got %b exp 0", to_arbiter_read); end
  endtask

  task automatic test_write_priority();
    cyc(); from_dcache_write = 1; from_dcache_read = 1; from_dcache_address = 32'h500; from_dcache_wdata = D5; #1;
    checks++; if (to_dcache_resp !== 1'b1) begin errors++; $display("FAIL wp_resp got %b exp 1", to_dcache_resp); end
    cyc(); from_dcache_write = 0; from_dcache_read = 0; #1;
    checks++; if (count !== 3'd1 || to_arbiter_read !== 1'b0) begin
      errors++; $display("FAIL wp_state got count=%0d rd=%b exp 1/0", count, to_arbiter_read);
    end
    cyc(); #1;
    checks++; if (to_arbiter_wdata !== D5) begin errors++; $display("FAIL wp_wb_data got %h exp %h", to_arbiter_wdata, D5); end
    from_arbiter_resp = 1;
    cyc(); from_arbiter_resp = 0; #1;
  endtask

  task automatic test_reset_mid_wb();
    for (int i = 0; i < 3; i++) begin
      cyc(); from_dcache_write = 1; from_dcache_address = 32'h300 + 32'(i * 32'h20); from_dcache_wdata = E[i]; #1;
    end
    cyc(); from_dcache_write = 0; #1;
    cyc(); #1;
    checks++; if (to_arbiter_write !== 1'b1 || count !== 3'd3) begin
      errors++; $display("FAIL rmw_pre got wr=%b count=%0d exp 1/3", to_arbiter_write, count);
    end
    rst = 1;
    cyc(); rst = 0; #1;
    checks++; if (count !== 3'd0 || to_arbiter_write !== 1'b0 || full !== 1'b0) begin
      errors++; $display("FAIL rmw_post got count=%0d wr=%b full=%b exp 0/0/0", count, to_arbiter_write, full);
    end
    cyc(); cyc(); #1;
    checks++; if (to_arbiter_write !== 1'b0 || to_arbiter_read !== 1'b0) begin
      errors++; $display("FAIL rmw_quiet got wr=%b rd=%b exp 0/0", to_arbiter_write, to_arbiter_read);
    end
  endtask

  initial begin
    D1 = {8{32'h1111_0001}}; D2 = {8{32'h2222_0002}}; D3 = {8{32'h3333_0003}};
    D4 = {8{32'h4444_0004}}; D5 = {8{32'h5555_0005}};
    for (int i = 0; i < 5; i++) E[i] = {8{32'hE000_0000 + 32'(i)}};
    test_reset();
    test_single_write();
    test_coalesce();
    test_full_wrap();
    test_read_hit_and_miss();
    test_write_priority();
    test_reset_mid_wb();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
